// File: rtl/gp_alu_sched.sv
// gp_alu_sched: round-robin sharing of one gp_alu among NUM_REQ requesters.
// Operands are registered before the ALU so that the multiplier path gets
// MUL_CYCLES full clock periods; the result is registered before it is returned.

// gp_alu: purely combinational 32-bit ALU with {zero, negative, overflow, carry} flags.
module gp_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        err
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] prod;
    logic        ovf;
    logic        carry;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // Low 32 bits of a product are identical for signed and unsigned operands.
    assign prod = a * b;

    // Operation decode; illegal codes yield a zero result and raise err.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            4'b0000: begin
                result = sum[31:0];
                carry  = sum[32];
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            4'b0001: begin
                result = diff[31:0];
                carry  = diff[32];
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            4'b0010: result = a & b;
            4'b0011: result = a | b;
            4'b0100: result = a ^ b;
            4'b0101: result = ~a;
            4'b0110: result = a << b[4:0];
            4'b0111: result = a >> b[4:0];
            4'b1000: result = prod;
            4'b1001: result = $signed(a) >>> b[4:0];
            default: err = 1'b1;
        endcase
        flags = {(result == 32'd0), result[31], ovf, carry};
    end

endmodule

module gp_alu_sched #(
    parameter int NUM_REQ    = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0]  req_op,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [3:0]        op_q;
    logic [1:0]        exec_cnt;

    logic              any_valid;
    logic [ID_W-1:0]   winner;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [3:0]        sel_op;

    logic [31:0]       alu_result;
    logic [3:0]        alu_flags;
    logic              alu_err;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_valid[ID_W'(idx)]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    assign sel_a  = req_a[int'(winner)*32 +: 32];
    assign sel_b  = req_b[int'(winner)*32 +: 32];
    assign sel_op = req_op[int'(winner)*4 +: 4];

    // Grant is combinational so the requester sees ready in its request cycle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    gp_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flags  (alu_flags),
        .err    (alu_err)
    );

    // Scheduler FSM: accept, execute for the op's cycle budget, hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            exec_cnt   <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        op_q     <= sel_op;
                        id_q     <= winner;
                        exec_cnt <= (sel_op == OP_MUL) ? 2'(MUL_CYCLES - 1) : 2'd0;
                        rr_ptr   <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_cnt == 2'd0) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                        rsp_err    <= alu_err;
                        rsp_valid  <= NUM_REQ'(1) << id_q;
                        state      <= RESP;
                    end else begin
                        exec_cnt <= exec_cnt - 2'd1;
                    end
                end
                RESP: begin
                    // Only the granted requester can release the response.
                    if (rsp_ready[id_q]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gp_alu_sched.sv
// Scoreboard bench for gp_alu_sched (NUM_REQ=2, MUL_CYCLES=2).
module tb_gp_alu_sched;

    localparam int N = 2;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [4*N-1:0]  req_op;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_result;
    logic [3:0]      rsp_flags;
    logic            rsp_err;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    gp_alu_sched #(.NUM_REQ(N), .MUL_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant sanity every cycle, scoreboard pop on each response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
                chk("ready_while_busy", 32'(busy), 32'd0);
            end
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.id));
                    chk("rsp_result", rsp_result, mon_e.res);
                    chk("rsp_flags", 32'(rsp_flags), 32'(mon_e.flags));
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_op[id*4 +: 4]  = op;
        req_valid[id]      = 1'b1;
    endtask

    // Wait for the grant of requester id, queue its expected response, then drop valid.
    task automatic wait_grant(input int id, input logic [31:0] r, input logic [3:0] f,
                              input logic e, output int k);
        k = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                k = cyc;
                break;
            end
        end
        chk("grant_seen", 32'(k >= 0), 32'd1);
        if (k >= 0) sb.push_back('{id: id, res: r, flags: f, err: e});
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp_latency(input int id, input int k, input int lat, input string name);
        int seen;
        seen = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin
                seen = cyc;
                break;
            end
        end
        chk(name, 32'(seen - k), 32'(lat));
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        chk("drain_queue", 32'(sb.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    // Both requesters valid continuously; expect alternating grants three cycles apart.
    task automatic run_both(input int n, input int first);
        int g;
        int last;
        int id;
        g    = 0;
        last = -1;
        set_req(0, 32'hFFFF_FFFF, 32'd1, OP_ADD);
        set_req(1, 32'd1, 32'd31, OP_SHL);
        for (int c = 0; c < 60 && g < n; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                id = req_ready[1] ? 1 : 0;
                chk("rr_order", 32'(id), 32'((first + g) % 2));
                if (last >= 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                if (id == 0) sb.push_back('{id: 0, res: 32'h0000_0000, flags: 4'b1001, err: 1'b0});
                else         sb.push_back('{id: 1, res: 32'h8000_0000, flags: 4'b0100, err: 1'b0});
                g++;
            end
        end
        chk("rr_grants", 32'(g), 32'(n));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int h;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // ADD with signed overflow; response two cycles after the grant cycle
        step();
        set_req(0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
        wait_grant(0, 32'h8000_0000, 4'b0110, 1'b0, k);
        wait_rsp_latency(0, k, 2, "add_latency");
        wait_drain();

        // SUB with borrow
        step();
        set_req(0, 32'd0, 32'd1, OP_SUB);
        wait_grant(0, 32'hFFFF_FFFF, 4'b0101, 1'b0, k);
        wait_drain();

        // Arithmetic shift right
        step();
        set_req(0, 32'h8000_0000, 32'd4, OP_SRA);
        wait_grant(0, 32'hF800_0000, 4'b0100, 1'b0, k);
        wait_drain();

        // Signed MUL, one cycle longer than ADD
        step();
        set_req(1, 32'hFFFF_FFFD, 32'd5, OP_MUL);
        wait_grant(1, 32'hFFFF_FFF1, 4'b0100, 1'b0, k);
        wait_rsp_latency(1, k, 3, "mul_latency");
        wait_drain();

        // Fairness: pointer is at 0 after the MUL from requester 1
        step();
        run_both(4, 0);

        // Illegal op with response backpressure; requester 0 waits behind it
        step();
        rsp_ready = 2'b01;
        set_req(1, 32'd123, 32'd456, 4'b1100);
        wait_grant(1, 32'd0, 4'b1000, 1'b1, k);
        set_req(0, 32'd5, 32'd6, OP_ADD);
        wait_rsp_latency(1, k, 2, "illegal_latency");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd2);
            chk("stall_result", rsp_result, 32'd0);
            chk("stall_flags", 32'(rsp_flags), 32'h8);
            chk("stall_err", 32'(rsp_err), 32'd1);
            chk("stall_ready0", 32'(req_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        h = cyc;
        chk("handshake_ready0", 32'(req_ready[0]), 32'd0);
        wait_grant(0, 32'd11, 4'b0000, 1'b0, k);
        chk("grant_after_handshake", 32'(k - h), 32'd1);
        wait_drain();

        // Reset during MUL execution: response dropped, outputs cleared at once
        step();
        rsp_ready = '1;
        set_req(0, 32'h10, 32'h10, OP_MUL);
        wait_grant(0, 32'h100, 4'b0000, 1'b0, k);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_result", rsp_result, 32'd0);
        chk("midrst_flags", 32'(rsp_flags), 32'd0);
        chk("midrst_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pointer back at 0: requester 0 wins first, then requester 1's fresh request
        step();
        run_both(2, 0);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
